// File: rtl/eth_measurer_sweep.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_measurer_sweep                                           |
// | Description : Drives the latency measurer coordinator through a packet     |
// |               size sweep, reduces ping/pong samples per size to RTT        |
// |               min/max/sum and good/lost counts, and emits one record per   |
// |               size over a valid/ready handshake.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module eth_measurer_sweep (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] psize_min,
    input  logic [15:0] psize_max,
    input  logic [15:0] psize_step,
    input  logic [15:0] samples,
    output logic        enable,
    output logic [15:0] psize_req,
    output logic        coord_rst,
    input  logic        done,
    input  logic [31:0] ping_time,
    input  logic [31:0] pong_time,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_psize,
    output logic [32:0] res_rtt_min,
    output logic [32:0] res_rtt_max,
    output logic [63:0] res_rtt_sum,
    output logic [15:0] res_good,
    output logic [15:0] res_lost,
    output logic        busy,
    output logic        sweep_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam logic [15:0] C_RESET_PSIZE = 16'd46;
    localparam logic [31:0] C_LOST_TIME   = 32'hFFFF_FFFF;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_max;
    logic [15:0] r_step;
    logic [15:0] r_samples;
    logic [15:0] r_idx;
    logic [32:0] r_min_acc;
    logic [32:0] r_max_acc;
    logic [63:0] r_sum_acc;
    logic [15:0] r_good_acc;
    logic [15:0] r_lost_acc;

    logic        w_last_sample;
    logic        w_lost;
    logic [32:0] w_rtt;
    logic [32:0] w_min_n;
    logic [32:0] w_max_n;
    logic [63:0] w_sum_n;
    logic [15:0] w_good_n;
    logic [15:0] w_lost_n;
    logic [16:0] w_next_size;
    logic        w_last_size;
    logic        w_take;
    logic        w_hs;

    assign w_last_sample = (r_idx == r_samples - 16'd1);
    assign w_lost        = (ping_time == C_LOST_TIME) || (pong_time == C_LOST_TIME);
    assign w_rtt         = {1'b0, ping_time} + {1'b0, pong_time};
    assign w_next_size   = {1'b0, psize_req} + {1'b0, r_step};
    assign w_last_size   = (r_step == 16'd0) || (w_next_size > {1'b0, r_max}) || w_next_size[16];
    assign w_take        = (r_state == ST_RUN) && done && !stop;
    assign w_hs          = (r_state == ST_EMIT) && res_ready && !stop;
    assign busy          = (r_state != ST_IDLE);
    assign res_valid     = (r_state == ST_EMIT);

    // Accumulator values including the sample currently strobed by done
    always_comb begin
        w_min_n  = r_min_acc;
        w_max_n  = r_max_acc;
        w_sum_n  = r_sum_acc;
        w_good_n = r_good_acc;
        w_lost_n = r_lost_acc;
        if (w_lost) begin
            w_lost_n = r_lost_acc + 16'd1;
        end else begin
            if (w_rtt < r_min_acc) w_min_n = w_rtt;
            if (w_rtt > r_max_acc) w_max_n = w_rtt;
            w_sum_n  = r_sum_acc + {31'd0, w_rtt};
            w_good_n = r_good_acc + 16'd1;
        end
    end

    // Next-state logic and the coordinator enable; enable drops with the final
    // done so a zero-delay coordinator cannot launch an extra measurement
    always_comb begin
        w_state_nxt = r_state;
        enable      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                enable = !stop && !(done && w_last_sample);
                if (stop)                        w_state_nxt = ST_IDLE;
                else if (done && w_last_sample)  w_state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                if (stop)                        w_state_nxt = ST_IDLE;
                else if (res_ready)              w_state_nxt = w_last_size ? ST_IDLE : ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, sweep configuration, accumulators and the result record
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            psize_req   <= C_RESET_PSIZE;
            r_max       <= 16'd0;
            r_step      <= 16'd0;
            r_samples   <= 16'd1;
            r_idx       <= 16'd0;
            r_min_acc   <= '1;
            r_max_acc   <= '0;
            r_sum_acc   <= '0;
            r_good_acc  <= '0;
            r_lost_acc  <= '0;
            res_psize   <= '0;
            res_rtt_min <= '0;
            res_rtt_max <= '0;
            res_rtt_sum <= '0;
            res_good    <= '0;
            res_lost    <= '0;
            sweep_done  <= 1'b0;
            coord_rst   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            sweep_done <= 1'b0;
            coord_rst  <= stop && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        psize_req  <= psize_min;
                        r_max      <= psize_max;
                        r_step     <= psize_step;
                        r_samples  <= (samples == 16'd0) ? 16'd1 : samples;
                        r_idx      <= '0;
                        r_min_acc  <= '1;
                        r_max_acc  <= '0;
                        r_sum_acc  <= '0;
                        r_good_acc <= '0;
                        r_lost_acc <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_take) begin
                        if (w_last_sample) begin
                            // Publish the record and re-arm the accumulators for the next size
                            res_psize   <= psize_req;
                            res_rtt_min <= w_min_n;
                            res_rtt_max <= w_max_n;
                            res_rtt_sum <= w_sum_n;
                            res_good    <= w_good_n;
                            res_lost    <= w_lost_n;
                            r_idx       <= '0;
                            r_min_acc   <= '1;
                            r_max_acc   <= '0;
                            r_sum_acc   <= '0;
                            r_good_acc  <= '0;
                            r_lost_acc  <= '0;
                        end else begin
                            r_idx       <= r_idx + 16'd1;
                            r_min_acc   <= w_min_n;
                            r_max_acc   <= w_max_n;
                            r_sum_acc   <= w_sum_n;
                            r_good_acc  <= w_good_n;
                            r_lost_acc  <= w_lost_n;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_hs) begin
                        if (w_last_size) sweep_done <= 1'b1;
                        else             psize_req  <= w_next_size[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_measurer_sweep.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_eth_measurer_sweep                                        |
// | Description : Scoreboard bench for eth_measurer_sweep                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_eth_measurer_sweep;

    typedef struct packed {
        logic [15:0] psize;
        logic [32:0] mn;
        logic [32:0] mx;
        logic [63:0] sum;
        logic [15:0] good;
        logic [15:0] lost;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst, start, stop, done, res_ready;
    logic [15:0] psize_min, psize_max, psize_step, samples;
    logic [31:0] ping_time, pong_time;
    logic        enable, coord_rst, res_valid, busy, sweep_done;
    logic [15:0] psize_req, res_psize, res_good, res_lost;
    logic [32:0] res_rtt_min, res_rtt_max;
    logic [63:0] res_rtt_sum;

    rec_t q[$];
    int   total = 0;
    int   bad   = 0;

    eth_measurer_sweep dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .psize_min(psize_min), .psize_max(psize_max), .psize_step(psize_step), .samples(samples),
        .enable(enable), .psize_req(psize_req), .coord_rst(coord_rst),
        .done(done), .ping_time(ping_time), .pong_time(pong_time),
        .res_valid(res_valid), .res_ready(res_ready), .res_psize(res_psize),
        .res_rtt_min(res_rtt_min), .res_rtt_max(res_rtt_max), .res_rtt_sum(res_rtt_sum),
        .res_good(res_good), .res_lost(res_lost), .busy(busy), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    function automatic rec_t dut_rec();
        rec_t r;
        r = {res_psize, res_rtt_min, res_rtt_max, res_rtt_sum, res_good, res_lost};
        return r;
    endfunction

    // Sample source: 0 fixed 10/20, 1 loss scenario (5, lost, 9), 2 random with losses
    task automatic get_sample(input int pat, input int s, output logic [31:0] p, output logic [31:0] o);
        case (pat)
            0: begin p = 32'd10; o = 32'd20; end
            1: begin
                if (s == 0)      begin p = 32'd2;         o = 32'd3; end
                else if (s == 1) begin p = 32'hFFFF_FFFF; o = 32'd1; end
                else             begin p = 32'd4;         o = 32'd5; end
            end
            default: begin
                p = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                o = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
        endcase
    endtask

    task automatic run_sweep(input logic [15:0] mn, input logic [15:0] mx, input logic [15:0] st,
                             input logic [15:0] smp, input int pat, input int rdel, input int exp_recs);
        logic [15:0] size;
        logic [16:0] nxt;
        logic [31:0] p, o;
        logic [32:0] rtt;
        bit          last_sz;
        int          ns, nrec;
        rec_t        e, a;
        ns   = (smp == 16'd0) ? 1 : int'(smp);
        nrec = 0;
        @(negedge clk);
        psize_min = mn; psize_max = mx; psize_step = st; samples = smp; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if ({busy, enable, psize_req} !== {1'b1, 1'b1, mn}) begin
            bad++;
            $display("FAIL start_response: busy/enable/psize_req=%b/%b/%0d required 1/1/%0d", busy, enable, psize_req, mn);
        end
        size = mn;
        for (int k = 0; k < 2000; k++) begin
            e = '{psize: size, mn: '1, mx: '0, sum: '0, good: '0, lost: '0};
            for (int s = 0; s < ns; s++) begin
                get_sample(pat, s, p, o);
                @(negedge clk);
                done = 1'b1; ping_time = p; pong_time = o;
                #1;
                total++;
                if (enable !== (s != ns - 1)) begin
                    bad++;
                    $display("FAIL enable_in_done: size=%0d sample=%0d enable=%b required %b", size, s, enable, (s != ns - 1));
                end
                if (p == 32'hFFFF_FFFF || o == 32'hFFFF_FFFF) begin
                    e.lost++;
                end else begin
                    rtt = {1'b0, p} + {1'b0, o};
                    if (rtt < e.mn) e.mn = rtt;
                    if (rtt > e.mx) e.mx = rtt;
                    e.sum  = e.sum + {31'd0, rtt};
                    e.good++;
                end
                if (s == ns - 1) q.push_back(e);
                @(posedge clk);
            end
            @(negedge clk);
            done = 1'b0; ping_time = '0; pong_time = '0;
            #1;
            total++;
            if (res_valid !== 1'b1) begin
                bad++;
                $display("FAIL res_valid_after_last: res_valid=%b required 1", res_valid);
            end
            // Held off by the consumer: record must stay put and coordinator idle
            for (int r = 0; r < rdel; r++) begin
                total++;
                if ({dut_rec(), enable, res_valid} !== {q[0], 1'b0, 1'b1}) begin
                    bad++;
                    $display("FAIL backpressure_hold: cycle=%0d rec=%h en=%b vld=%b required rec=%h en=0 vld=1", r, dut_rec(), enable, res_valid, q[0]);
                end
                @(negedge clk);
                #1;
            end
            res_ready = 1'b1;
            a = dut_rec();
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty: record %h with nothing expected", a);
            end else begin
                e = q.pop_front();
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL record: got %h required %h", a, e);
                end
            end
            nrec++;
            nxt     = {1'b0, size} + {1'b0, st};
            last_sz = (st == 16'd0) || (nxt > {1'b0, mx}) || nxt[16];
            @(posedge clk);
            @(negedge clk);
            res_ready = 1'b0;
            #1;
            total++;
            if (last_sz) begin
                if ({res_valid, sweep_done, busy, enable} !== 4'b0100) begin
                    bad++;
                    $display("FAIL last_handshake: vld/sdone/busy/en=%b%b%b%b required 0100", res_valid, sweep_done, busy, enable);
                end
                @(negedge clk);
                #1;
                total++;
                if (sweep_done !== 1'b0) begin
                    bad++;
                    $display("FAIL sweep_done_pulse: sweep_done=%b required 0", sweep_done);
                end
                break;
            end else begin
                if ({res_valid, sweep_done, enable, psize_req} !== {3'b001, nxt[15:0]}) begin
                    bad++;
                    $display("FAIL next_size: vld/sdone/en=%b%b%b psize_req=%0d required 001 %0d", res_valid, sweep_done, enable, psize_req, nxt[15:0]);
                end
                size = nxt[15:0];
            end
        end
        total++;
        if (nrec != exp_recs || q.size() != 0) begin
            bad++;
            $display("FAIL record_count: got %0d records (%0d pending) required %0d", nrec, q.size(), exp_recs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; done = 1'b0; res_ready = 1'b0;
        psize_min = '0; psize_max = '0; psize_step = '0; samples = '0;
        ping_time = '0; pong_time = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({psize_req, res_valid, busy, sweep_done, coord_rst, enable} !== {16'd46, 5'b00000}) begin
            bad++;
            $display("FAIL reset_ctrl: psize_req=%0d vld/busy/sdone/crst/en=%b%b%b%b%b required 46 00000", psize_req, res_valid, busy, sweep_done, coord_rst, enable);
        end
        total++;
        if (dut_rec() !== '0) begin
            bad++;
            $display("FAIL reset_record: got %h required 0", dut_rec());
        end
    endtask

    task automatic test_basic();        run_sweep(16'd64, 16'd128, 16'd32, 16'd2, 0, 0, 3); endtask
    task automatic test_loss();         run_sweep(16'd100, 16'd100, 16'd10, 16'd3, 1, 0, 1); endtask
    task automatic test_no_extra();     run_sweep(16'd46, 16'd200, 16'd50, 16'd1, 2, 0, 4); endtask
    task automatic test_back_to_back(); run_sweep(16'd1000, 16'd1600, 16'd300, 16'd4, 2, 0, 3); endtask
    task automatic test_backpressure(); run_sweep(16'd300, 16'd350, 16'd50, 16'd2, 2, 20, 2); endtask

    task automatic test_boundaries();
        run_sweep(16'd65500, 16'd65535, 16'd40, 16'd2, 2, 0, 1);
        run_sweep(16'd65500, 16'd65535, 16'd35, 16'd1, 0, 0, 2);
        run_sweep(16'd300, 16'd1000, 16'd0, 16'd1, 2, 1, 1);
        run_sweep(16'd10, 16'd30, 16'd10, 16'd0, 2, 0, 3);
        run_sweep(16'd500, 16'd100, 16'd10, 16'd1, 0, 0, 1);
    endtask

    task automatic test_abort();
        bit saw_done;
        saw_done = 1'b0;
        // stop alongside start in idle: nothing happens
        @(negedge clk);
        psize_min = 16'd200; psize_max = 16'd400; psize_step = 16'd100; samples = 16'd3;
        start = 1'b1; stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        #1;
        total++;
        if ({busy, coord_rst} !== 2'b00) begin
            bad++;
            $display("FAIL stop_beats_start: busy/coord_rst=%b%b required 00", busy, coord_rst);
        end
        // abort mid-sample
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; done = 1'b1; ping_time = 32'd7; pong_time = 32'd8;
        @(posedge clk);
        @(negedge clk);
        done = 1'b0; stop = 1'b1;
        #1;
        total++;
        if (enable !== 1'b0) begin
            bad++;
            $display("FAIL stop_gates_enable: enable=%b required 0", enable);
        end
        @(posedge clk);
        saw_done = saw_done | sweep_done;
        @(negedge clk);
        stop = 1'b0;
        #1;
        total++;
        if ({coord_rst, busy, res_valid} !== 3'b100) begin
            bad++;
            $display("FAIL abort_response: coord_rst/busy/vld=%b%b%b required 100", coord_rst, busy, res_valid);
        end
        saw_done = saw_done | sweep_done;
        @(negedge clk);
        #1;
        total++;
        if ({coord_rst, saw_done, sweep_done, res_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL abort_after: coord_rst=%b sweep_done_seen=%b sdone=%b vld=%b required 0000", coord_rst, saw_done, sweep_done, res_valid);
        end
        // stop in idle has no effect
        stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stop = 1'b0;
        #1;
        total++;
        if ({coord_rst, busy} !== 2'b00) begin
            bad++;
            $display("FAIL idle_stop: coord_rst/busy=%b%b required 00", coord_rst, busy);
        end
        run_sweep(16'd200, 16'd400, 16'd100, 16'd3, 0, 0, 3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loss();
        test_no_extra();
        test_back_to_back();
        test_backpressure();
        test_boundaries();
        test_abort();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_measurer_sweep.md
# eth_measurer_sweep

Sequencer that drives the Ethernet latency measurer coordinator through a packet-size sweep. For each size it enables the coordinator, collects a fixed number of ping/pong samples from its `done` pulses, and reduces them to min/max/sum round-trip time and a loss count. It then hands one result record per size to the stats/AXI side over a valid/ready handshake. It sits between the register file and the coordinator, driving the coordinator's `enable` and `psize_req`.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  pulse; begins a sweep (only honoured in ST_IDLE)
- `stop`  in  1  pulse; aborts the sweep; wins over `start` in the same cycle
- `psize_min`  in  16  first packet size
- `psize_max`  in  16  last allowed packet size
- `psize_step`  in  16  size increment
- `samples`  in  16  samples per size; 0 is treated as 1
- `enable`  out  1  to coordinator `enable`; combinational
- `psize_req`  out  16  to coordinator `psize_req`; registered
- `coord_rst`  out  1  one-cycle pulse on abort; integrator ORs it into the coordinator `rst`
- `done`  in  1  coordinator result strobe
- `ping_time`  in  32  coordinator ping time; all ones = lost
- `pong_time`  in  32  coordinator pong time; all ones = lost
- `res_valid`  out  1  result record valid
- `res_ready`  in  1  result consumer ready
- `res_psize`  out  16  size of this record
- `res_rtt_min`  out  33  minimum of ping_time+pong_time over good samples
- `res_rtt_max`  out  33  maximum RTT over good samples
- `res_rtt_sum`  out  64  sum of RTT over good samples
- `res_good`  out  16  good sample count
- `res_lost`  out  16  lost sample count
- `busy`  out  1  high whenever state is not ST_IDLE
- `sweep_done`  out  1  one-cycle pulse after the last record is accepted

## Operation
- States: ST_IDLE, ST_RUN, ST_EMIT.
- **ST_IDLE**
  - On `start` (and no `stop`): latch `psize_min`, `psize_max`, `psize_step` and `samples` (0 becomes 1); load `psize_req` with `psize_min`.
  - Clear the accumulators: min = all ones, max = 0, sum = 0, good = 0, lost = 0, sample index = 0.
  - Go to ST_RUN.
  - `done` is ignored.
- **ST_RUN**
  - `enable = (state==ST_RUN) & ~stop & ~(done & last_sample)`. `last_sample` means the sample index equals latched `samples`-1.
  - Gating `enable` in the same cycle as the final `done` stops the coordinator starting an extra measurement when its delay is 0.
  - On `done`, the sample is lost if either `ping_time` or `pong_time` is 32'hFFFFFFFF. Lost samples increment the lost count only.
  - Otherwise rtt = zero-extended 33-bit sum. Update min/max, add rtt to the 64-bit sum, and increment good.
  - Increment the sample index on every `done`. On the last sample, capture the final accumulator values (including this sample) into `res_*` and go to ST_EMIT.
- **ST_EMIT**
  - `res_valid` = 1; `res_*` are held stable until the handshake (`res_valid & res_ready`).
  - On handshake, compute next = `psize_req` + step in 17 bits.
  - Last size when step == 0, or next > `psize_max`, or next[16] == 1. In that case go to ST_IDLE and pulse `sweep_done`.
  - Otherwise `psize_req` <= next[15:0], clear the accumulators, and return to ST_RUN.
  - `done` is ignored here (the coordinator is disabled).
- `psize_min` > `psize_max`: exactly one record, at `psize_min`.
- **stop** in ST_RUN or ST_EMIT:
  - Next state is ST_IDLE; `coord_rst` pulses for one cycle.
  - `res_valid` drops and the partial record is discarded; no `sweep_done`.
  - In ST_IDLE, `stop` has no effect and does not pulse `coord_rst`.
- If no record was good: `res_rtt_min` = 33'h1FFFFFFFF, max = 0, sum = 0.
- Accumulator widths never wrap: 65535 × (2^33−1) < 2^64.

## Timing
- Reset values:
  - state ST_IDLE
  - `psize_req` = 46 (matches the coordinator reset size)
  - `res_valid`, `busy`, `sweep_done`, `coord_rst` = 0
  - all `res_*` = 0
  - `enable` = 0
- `start` at cycle N: `busy` and `enable` are high, and `psize_req` = `psize_min`, at N+1.
- Final `done` at cycle D: `enable` is low in D itself; `res_valid` = 1 with the record at D+1.
- Handshake at cycle H:
  - Next size: at H+1 `res_valid` = 0, `psize_req` is updated and `enable` = 1.
  - Last size: at H+1 `sweep_done` = 1 and `busy` = 0.
- `stop` at cycle S: `enable` is low in S; `coord_rst` = 1 and `busy` = 0 at S+1.
- `rst` mid-sweep returns all state to reset values at the next edge; no `sweep_done`.

## Test plan
- **Basic sweep**: min=64, max=128, step=32, samples=2, done pulses all with ping=10/pong=20 -> 3 records (64, 96, 128), each min=max=30, sum=60, good=2, lost=0; one `sweep_done`.
- **Loss accounting**: samples=3 with a good RTT of 5, a sample with ping all ones, then a good RTT of 9 -> min=5, max=9, sum=14, good=2, lost=1.
- **No extra trigger**: samples=1 with a zero-delay coordinator model -> `enable` is 0 in the `done` cycle; exactly one measurement per size.
- **Backpressure**: `res_ready` held low for 20 cycles -> record stable, `enable` low throughout, next size starts the cycle after ready.
- **Boundaries**: min=65500, max=65535, step=40 -> one record; step=0 -> one record; samples=0 -> one sample per size.
- **Abort**: `stop` mid-sample -> `coord_rst` one-cycle pulse, no record, no `sweep_done`; a subsequent `start` sweeps cleanly from `psize_min`.
